// File: rtl/custom_wr_ingress.sv
// Write-domain ingress for an async FIFO: 2-entry skid buffer between a valid/ready
// producer and the FIFO write port, throttled by the registered full/almost-full flags.
module custom_wr_ingress #(
    parameter int DATASIZE = 8,
    parameter int CNTW     = 16
) (
    input  logic                wclk_i,
    input  logic                wrst_i,
    input  logic                flush_i,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATASIZE-1:0] in_data,
    input  logic                fifo_full,
    input  logic                fifo_almost_full,
    output logic                wen,
    output logic [DATASIZE-1:0] wdata,
    output logic [CNTW-1:0]     accept_cnt,
    output logic [CNTW-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state;
    logic [DATASIZE-1:0] e0;
    logic [DATASIZE-1:0] e1;
    logic                pop;
    logic                acc;
    logic                stall_evt;

    // in_ready sees only registered state and the two registered flags, never in_valid.
    // wen is additionally held low while reset is asserted, before state is known.
    assign pop       = (state != EMPTY) & ~fifo_full & ~flush_i & ~wrst_i;
    assign wen       = pop;
    assign wdata     = e0;
    assign in_ready  = ~flush_i & ((state == EMPTY) | ((state == ONE) & ~fifo_almost_full));
    assign acc       = in_valid & in_ready;
    assign stall_evt = (state != EMPTY) & fifo_full & ~flush_i;

    always_ff @(posedge wclk_i) begin
        if (wrst_i) begin
            state      <= EMPTY;
            e0         <= '0;
            e1         <= '0;
            accept_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (flush_i) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (acc) begin
                            e0    <= in_data;
                            state <= ONE;
                        end
                    end
                    ONE: begin
                        case ({acc, pop})
                            2'b10: begin
                                e1    <= in_data;
                                state <= TWO;
                            end
                            2'b01: state <= EMPTY;
                            2'b11: e0 <= in_data;
                            default: state <= ONE;
                        endcase
                    end
                    TWO: begin
                        if (pop) begin
                            e0    <= e1;
                            state <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
            if (acc) begin
                accept_cnt <= accept_cnt + CNTW'(1);
            end
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_custom_wr_ingress.sv
// Directed bench for custom_wr_ingress: a default-width instance for the datapath
// and a CNTW=4 instance for counter saturation and wrap.
module tb_custom_wr_ingress;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [7:0]  data;
    logic        full;
    logic        afull;
    logic        wen;
    logic [7:0]  wdata;
    logic [15:0] acc_cnt;
    logic [15:0] stl_cnt;

    logic        s_rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_full;
    logic        s_wen;
    logic [7:0]  s_wdata;
    logic [3:0]  s_acc_cnt;
    logic [3:0]  s_stl_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    custom_wr_ingress #(.DATASIZE(8), .CNTW(16)) dut (
        .wclk_i           (clk),
        .wrst_i           (rst),
        .flush_i          (flush),
        .in_valid         (valid),
        .in_ready         (ready),
        .in_data          (data),
        .fifo_full        (full),
        .fifo_almost_full (afull),
        .wen              (wen),
        .wdata            (wdata),
        .accept_cnt       (acc_cnt),
        .stall_cnt        (stl_cnt)
    );

    custom_wr_ingress #(.DATASIZE(8), .CNTW(4)) dut_small (
        .wclk_i           (clk),
        .wrst_i           (s_rst),
        .flush_i          (1'b0),
        .in_valid         (s_valid),
        .in_ready         (s_ready),
        .in_data          (s_data),
        .fifo_full        (s_full),
        .fifo_almost_full (1'b0),
        .wen              (s_wen),
        .wdata            (s_wdata),
        .accept_cnt       (s_acc_cnt),
        .stall_cnt        (s_stl_cnt)
    );

    // Drive one cycle's inputs just after the falling edge; checks follow 1ns later,
    // so combinational outputs reflect this cycle and counters reflect the last edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                                 input logic f, input logic af, input logic fl);
        @(negedge clk);
        rst   = r;
        valid = v;
        data  = d;
        full  = f;
        afull = af;
        flush = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        s_rst   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_full  = 1'b0;

        // Reset and idle
        repeat (3) applyStimulus(1, 0, 8'h00, 0, 0, 0);
        s_rst = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("reset_wen", {31'd0, wen}, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd1);
        checkOutput("reset_wdata", {24'd0, wdata}, 32'd0);
        checkOutput("reset_acc", {16'd0, acc_cnt}, 32'd0);
        checkOutput("reset_stall", {16'd0, stl_cnt}, 32'd0);

        // Streaming 16 words back to back
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 8'(i), 0, 0, 0);
            checkOutput("stream_ready", {31'd0, ready}, 32'd1);
            checkOutput("stream_wen", {31'd0, wen}, (i != 0) ? 32'd1 : 32'd0);
            if (i != 0) checkOutput("stream_wdata", {24'd0, wdata}, 32'(i - 1));
        end
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("stream_last_wen", {31'd0, wen}, 32'd1);
        checkOutput("stream_last_wdata", {24'd0, wdata}, 32'h0F);
        checkOutput("stream_acc", {16'd0, acc_cnt}, 32'd16);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("stream_idle_wen", {31'd0, wen}, 32'd0);

        // Full stall: two words buffered, five stalled cycles
        applyStimulus(0, 1, 8'hA1, 1, 0, 0);
        checkOutput("stall_a1_ready", {31'd0, ready}, 32'd1);
        checkOutput("stall_a1_wen", {31'd0, wen}, 32'd0);
        applyStimulus(0, 1, 8'hA2, 1, 0, 0);
        checkOutput("stall_a2_ready", {31'd0, ready}, 32'd1);
        checkOutput("stall_a2_wen", {31'd0, wen}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 8'hEE, 1, 0, 0);
            checkOutput("stall_two_ready", {31'd0, ready}, 32'd0);
            checkOutput("stall_two_wen", {31'd0, wen}, 32'd0);
        end
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("stall_cnt5", {16'd0, stl_cnt}, 32'd5);
        checkOutput("drain_a1_wen", {31'd0, wen}, 32'd1);
        checkOutput("drain_a1_wdata", {24'd0, wdata}, 32'hA1);
        checkOutput("drain_two_ready", {31'd0, ready}, 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("drain_a2_wen", {31'd0, wen}, 32'd1);
        checkOutput("drain_a2_wdata", {24'd0, wdata}, 32'hA2);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("drain_done_wen", {31'd0, wen}, 32'd0);
        checkOutput("drain_acc", {16'd0, acc_cnt}, 32'd18);

        // Almost-full throttle: accept, write, accept, write...
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 8'(8'hB0 + k), 0, 1, 0);
            if (k % 2 == 0) begin
                checkOutput("af_empty_ready", {31'd0, ready}, 32'd1);
                checkOutput("af_empty_wen", {31'd0, wen}, 32'd0);
            end else begin
                checkOutput("af_one_ready", {31'd0, ready}, 32'd0);
                checkOutput("af_one_wen", {31'd0, wen}, 32'd1);
                checkOutput("af_one_wdata", {24'd0, wdata}, 32'(8'hB0 + k - 1));
            end
        end
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("af_acc", {16'd0, acc_cnt}, 32'd21);
        checkOutput("af_end_wen", {31'd0, wen}, 32'd0);

        // Flush with two buffered words
        applyStimulus(0, 1, 8'h55, 1, 0, 0);
        applyStimulus(0, 1, 8'h66, 1, 0, 0);
        applyStimulus(0, 1, 8'h77, 0, 0, 1);
        checkOutput("flush_wen", {31'd0, wen}, 32'd0);
        checkOutput("flush_ready", {31'd0, ready}, 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("post_flush_wen", {31'd0, wen}, 32'd0);
        checkOutput("post_flush_ready", {31'd0, ready}, 32'd1);
        checkOutput("post_flush_acc", {16'd0, acc_cnt}, 32'd23);
        checkOutput("post_flush_stall", {16'd0, stl_cnt}, 32'd6);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("post_flush_wen2", {31'd0, wen}, 32'd0);

        // Reset mid-stream discards the buffered word
        applyStimulus(0, 1, 8'h99, 1, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0, 0);
        checkOutput("midrst_wen", {31'd0, wen}, 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("midrst_after_wen", {31'd0, wen}, 32'd0);
        checkOutput("midrst_acc", {16'd0, acc_cnt}, 32'd0);
        checkOutput("midrst_stall", {16'd0, stl_cnt}, 32'd0);

        // Small counters: stall saturation, then accept wrap
        s_valid = 1'b1;
        s_data  = 8'h01;
        s_full  = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("sat_stall", {28'd0, s_stl_cnt}, 32'd15);
        checkOutput("sat_wen", {31'd0, s_wen}, 32'd0);
        s_full  = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 8'(8'h10 + i);
            applyStimulus(0, 0, 8'h00, 0, 0, 0);
        end
        s_valid = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("wrap_acc", {28'd0, s_acc_cnt}, 32'd1);
        checkOutput("wrap_last_wdata", {24'd0, s_wdata}, 32'h1F);
        checkOutput("sat_stall_hold", {28'd0, s_stl_cnt}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
